// File: rtl/inverse_substitution_layer.sv
// Iterative inverse ASCON S-box layer over a 320-bit bit-sliced state, P columns per clock.
// Define INV_SBOX_SELFCHECK_EN to add a forward re-substitution check that drives o_error.
package ascon_pkg;
   localparam logic [4:0] C_LUT_INV_SBOX [32] = '{
      5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
      5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
      5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
      5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
   };
`ifdef INV_SBOX_SELFCHECK_EN
   localparam logic [4:0] C_LUT_SBOX [32] = '{
      5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
      5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
      5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
      5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
   };
`endif
endpackage

module inverse_substitution_layer
   import ascon_pkg::*;
#(
   parameter int G_NB_COLUMNS_PER_CYCLE = 8
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [319:0] i_state,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [319:0] o_state,
   output logic         o_error
);
   localparam int unsigned P   = G_NB_COLUMNS_PER_CYCLE;
   localparam int unsigned NCH = 64 / P;
   localparam int unsigned LP  = $clog2(P);
   localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(NCH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   if (!(P == 1 || P == 2 || P == 4 || P == 8 || P == 16 || P == 32 || P == 64)) begin : g_bad_p
      $error("G_NB_COLUMNS_PER_CYCLE must be a power of two between 1 and 64");
   end

   logic [1:0]     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [319:0]   data_q, data_d;
   logic           err_q, err_d;
   logic [5*P-1:0] inv_out;
`ifdef INV_SBOX_SELFCHECK_EN
   logic           phase_q, phase_d;
   logic           mism_q, mism_d;
   logic [319:0]   shadow_q, shadow_d;
   logic           chunk_mism;
`endif

   function automatic logic [5:0] col_idx(input logic [CW-1:0] cnt, input int unsigned c);
      return 6'((32'(cnt) << LP) + c);
   endfunction

   // Column j = {x0[j], x1[j], x2[j], x3[j], x4[j]}, x0 in the MSB.
   function automatic logic [4:0] col_get(input logic [319:0] s, input logic [5:0] j);
      logic [63:0] x0, x1, x2, x3, x4;
      {x0, x1, x2, x3, x4} = s;
      return {x0[j], x1[j], x2[j], x3[j], x4[j]};
   endfunction

   function automatic logic [319:0] col_set(input logic [319:0] s, input logic [5:0] j,
                                            input logic [4:0] v);
      logic [63:0] x0, x1, x2, x3, x4;
      {x0, x1, x2, x3, x4} = s;
      {x0[j], x1[j], x2[j], x3[j], x4[j]} = v;
      return {x0, x1, x2, x3, x4};
   endfunction

   always_comb begin
      inv_out = '0;
      for (int unsigned c = 0; c < P; c++) begin
         inv_out[5*c +: 5] = C_LUT_INV_SBOX[col_get(data_q, col_idx(cnt_q, c))];
      end
   end

`ifdef INV_SBOX_SELFCHECK_EN
   always_comb begin
      chunk_mism = 1'b0;
      for (int unsigned c = 0; c < P; c++) begin
         chunk_mism |= (C_LUT_SBOX[col_get(data_q, col_idx(cnt_q, c))]
                        != col_get(shadow_q, col_idx(cnt_q, c)));
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      err_d   = err_q;
`ifdef INV_SBOX_SELFCHECK_EN
      phase_d  = phase_q;
      mism_d   = mism_q;
      shadow_d = shadow_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               data_d  = i_state;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = S_BUSY;
`ifdef INV_SBOX_SELFCHECK_EN
               shadow_d = i_state;
               phase_d  = 1'b0;
               mism_d   = 1'b0;
`endif
            end
         end
         S_BUSY: begin
`ifdef INV_SBOX_SELFCHECK_EN
            // Second pass only compares; the register keeps the inverse result.
            if (!phase_q) begin
               for (int unsigned c = 0; c < P; c++)
                  data_d = col_set(data_d, col_idx(cnt_q, c), inv_out[5*c +: 5]);
            end else begin
               mism_d = mism_q | chunk_mism;
            end
`else
            for (int unsigned c = 0; c < P; c++)
               data_d = col_set(data_d, col_idx(cnt_q, c), inv_out[5*c +: 5]);
`endif
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_LAST) begin
               cnt_d = '0;
`ifdef INV_SBOX_SELFCHECK_EN
               if (!phase_q) begin
                  phase_d = 1'b1;
               end else begin
                  state_d = S_DONE;
                  err_d   = mism_q | chunk_mism;
               end
`else
               state_d = S_DONE;
`endif
            end
         end
         S_DONE: begin
            if (i_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
`ifdef INV_SBOX_SELFCHECK_EN
         phase_q  <= 1'b0;
         mism_q   <= 1'b0;
         shadow_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         err_q   <= err_d;
`ifdef INV_SBOX_SELFCHECK_EN
         phase_q  <= phase_d;
         mism_q   <= mism_d;
         shadow_q <= shadow_d;
`endif
      end
   end

   assign o_ready = (state_q == S_IDLE);
   assign o_valid = (state_q == S_DONE);
   assign o_state = data_q;
   assign o_error = err_q;

endmodule
